// File: rtl/rx_pkg.sv
// Shared constants and types for the Gen1/Gen2 RX descrambler lane logic.
package rx_pkg;

  localparam logic [7:0]  K_COM    = 8'hBC;
  localparam logic [7:0]  K_SKP    = 8'h1C;
  localparam logic [15:0] SCR_SEED = 16'hFFFF;
  localparam logic [15:0] SCR_POLY = 16'h0039;

  localparam logic [1:0] SEL_8  = 2'd0;
  localparam logic [1:0] SEL_16 = 2'd1;
  localparam logic [1:0] SEL_32 = 2'd2;

  // adv = 0 marks a SKP byte; com marks a COM that re-seeds the LFSR
  typedef struct packed {
    logic adv;
    logic com;
  } byte_class_t;

  // Bytes of the PIPE word that take part in descrambling for a width code.
  function automatic logic [3:0] active_mask(input logic [1:0] sel);
    case (sel)
      SEL_8:   active_mask = 4'b0001;
      SEL_16:  active_mask = 4'b0011;
      default: active_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/scr_byte_step.sv
// One byte of the scrambling LFSR: produces the 8-bit key and the state
// that the next byte sees.
module scr_byte_step
  import rx_pkg::*;
#(
  parameter logic [15:0] SEED = SCR_SEED,
  parameter logic [15:0] POLY = SCR_POLY
) (
  input  logic [15:0] s,
  input  byte_class_t cls,
  output logic [7:0]  key,
  output logic [15:0] s_next
);

  logic [15:0] t;

  always_comb begin
    t   = s;
    key = '0;
    // Key bits leave from the MSB, least-significant key bit first.
    for (int j = 0; j < 8; j++) begin
      key[j] = t[15];
      t      = {t[14:0], 1'b0} ^ (t[15] ? POLY : 16'h0000);
    end
    s_next = s;
    if (cls.adv) begin
      s_next = cls.com ? SEED : t;
    end
  end

endmodule

// File: rtl/rx_descrambler.sv
// Single-lane 8b/10b RX descrambler: chains four byte steps across the PIPE
// word and registers data, K flags and valid with one cycle of latency.
module rx_descrambler
  import rx_pkg::*;
#(
  parameter logic [15:0] SEED = SCR_SEED,
  parameter logic [15:0] POLY = SCR_POLY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataIn,
  input  logic [3:0]  dataKIn,
  input  logic        validIn,
  input  logic        patternReset,
  input  logic [3:0]  advance,
  input  logic [1:0]  LFSRSel,
  input  logic        turnOff,
  output logic [31:0] dataOut,
  output logic [3:0]  dataKOut,
  output logic        validOut
);

  // Valid-only stream: a word is transferred on every cycle validIn is high;
  // there is no ready, the block always accepts and never stalls.

  logic [15:0]       lfsr;
  logic [4:0][15:0]  s_chain;
  logic [3:0][7:0]   key;
  byte_class_t [3:0] cls;

  logic [3:0]  mask;
  logic        com_hit;
  logic [31:0] d_next;
  logic [3:0]  k_next;
  logic [15:0] s_final;

  assign s_chain[0] = lfsr;

  for (genvar g = 0; g < 4; g++) begin : g_step
    assign cls[g] = '{adv: advance[g],
                      com: dataKIn[g] && (dataIn[8*g +: 8] == K_COM) && patternReset};

    scr_byte_step #(.SEED(SEED), .POLY(POLY)) u_step (
      .s      (s_chain[g]),
      .cls    (cls[g]),
      .key    (key[g]),
      .s_next (s_chain[g+1])
    );
  end

  always_comb begin
    mask    = active_mask(LFSRSel);
    com_hit = 1'b0;
    d_next  = '0;
    k_next  = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        d_next[8*i +: 8] = (advance[i] && !dataKIn[i]) ? (dataIn[8*i +: 8] ^ key[i])
                                                       : dataIn[8*i +: 8];
        k_next[i] = dataKIn[i];
        com_hit   = com_hit | (cls[i].adv & cls[i].com);
      end
    end

    case (LFSRSel)
      SEL_8:   s_final = s_chain[1];
      SEL_16:  s_final = s_chain[2];
      default: s_final = s_chain[4];
    endcase
    // A COM that was not seen in the active bytes still re-seeds after the word.
    if (patternReset && !com_hit) begin
      s_final = SEED;
    end

    if (turnOff) begin
      d_next  = dataIn;
      k_next  = dataKIn;
      s_final = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= SEED;
      dataOut  <= '0;
      dataKOut <= '0;
      validOut <= 1'b0;
    end else if (validIn) begin
      lfsr     <= s_final;
      dataOut  <= d_next;
      dataKOut <= k_next;
      validOut <= 1'b1;
    end else begin
      validOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_descrambler.sv
// Self-checking bench for rx_descrambler: directed vector table, hand-written
// gap/reset sequences and randomized words against a keystream-position model.
module tb_rx_descrambler;
  import rx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataIn = '0;
  logic [3:0]  dataKIn = '0;
  logic        validIn = 1'b0;
  logic        patternReset = 1'b0;
  logic [3:0]  advance = '0;
  logic [1:0]  LFSRSel = '0;
  logic        turnOff = 1'b0;
  logic [31:0] dataOut;
  logic [3:0]  dataKOut;
  logic        validOut;

  rx_descrambler dut (
    .clk          (clk),
    .reset        (reset),
    .dataIn       (dataIn),
    .dataKIn      (dataKIn),
    .validIn      (validIn),
    .patternReset (patternReset),
    .advance      (advance),
    .LFSRSel      (LFSRSel),
    .turnOff      (turnOff),
    .dataOut      (dataOut),
    .dataKOut     (dataKOut),
    .validOut     (validOut)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [36:0] exp_q[$];
  logic [7:0]  ks[0:1023];   // keystream byte k is the key for the k-th byte after a seed
  int          pos = 0;
  logic [36:0] last_exp = '0;
  logic [36:0] model_e;

  typedef struct {
    logic        v, t, pr;
    logic [1:0]  sel;
    logic [3:0]  adv, kin;
    logic [31:0] din;
    logic        exp_v;
    logic [3:0]  exp_k;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic v, t, pr, input logic [1:0] sel,
                              input logic [3:0] adv, kin, input logic [31:0] din,
                              input logic ev, input logic [3:0] ek, input logic [31:0] ed);
    vec_t r;
    r.v = v; r.t = t; r.pr = pr; r.sel = sel; r.adv = adv; r.kin = kin; r.din = din;
    r.exp_v = ev; r.exp_k = ek; r.exp_d = ed;
    return r;
  endfunction

  // Reference: track how many keystream bytes have been consumed since the last seed.
  task automatic model(input logic rst, v, t, pr, input logic [1:0] sel,
                       input logic [3:0] adv, kin, input logic [31:0] din);
    int n;
    logic com;
    logic [31:0] d;
    logic [3:0] k;
    logic [7:0] b;
    if (rst) begin
      pos = 0;
      model_e = '0;
    end else if (!v) begin
      model_e = {1'b0, last_exp[35:0]};
    end else if (t) begin
      pos = 0;
      model_e = {1'b1, kin, din};
    end else begin
      n = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
      com = 1'b0; d = '0; k = '0;
      for (int i = 0; i < n; i++) begin
        b = din[8*i +: 8];
        if (!adv[i]) d[8*i +: 8] = b;
        else if (kin[i] && b == K_COM && pr) begin d[8*i +: 8] = b; pos = 0; com = 1'b1; end
        else if (kin[i]) begin d[8*i +: 8] = b; pos++; end
        else begin d[8*i +: 8] = b ^ ks[pos]; pos++; end
        k[i] = kin[i];
      end
      if (pr && !com) pos = 0;
      model_e = {1'b1, k, d};
    end
    last_exp = model_e;
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic drive(input logic rst, v, t, pr, input logic [1:0] sel,
                       input logic [3:0] adv, kin, input logic [31:0] din);
    @(negedge clk);
    reset = rst; validIn = v; turnOff = t; patternReset = pr;
    LFSRSel = sel; advance = adv; dataKIn = kin; dataIn = din;
    model(rst, v, t, pr, sel, adv, kin, din);
  endtask

  task automatic check_out(input string name);
    logic [36:0] got, exp;
    @(posedge clk);
    #1;
    got = {validOut, dataKOut, dataOut};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got v=%b k=%b d=%h", name, got[36], got[35:32], got[31:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got v=%b k=%b d=%h, expected v=%b k=%b d=%h", name,
                 got[36], got[35:32], got[31:0], exp[36], exp[35:32], exp[31:0]);
      end
    end
  endtask

  task automatic step_c(input string name, input logic rst, v, t, pr, input logic [1:0] sel,
                        input logic [3:0] adv, kin, input logic [31:0] din,
                        input logic ev, input logic [3:0] ek, input logic [31:0] ed);
    drive(rst, v, t, pr, sel, adv, kin, din);
    exp_q.push_back({ev, ek, ed});
    check_out(name);
  endtask

  task automatic step_m(input string name, input logic rst, v, t, pr, input logic [1:0] sel,
                        input logic [3:0] adv, kin, input logic [31:0] din);
    drive(rst, v, t, pr, sel, adv, kin, din);
    exp_q.push_back(model_e);
    check_out(name);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] s;
    logic rst, v, t, pr;
    logic [1:0] sel;
    logic [3:0] adv, kin;
    logic [31:0] din;
    logic [7:0] b;
    int since;

    s = 16'hFFFF;
    for (int p = 0; p < 1024; p++) begin
      for (int j = 0; j < 8; j++) begin
        ks[p][j] = s[15];
        s = (s << 1) ^ (s[15] ? 16'h0039 : 16'h0000);
      end
    end

    //        v  t  pr sel   adv    kin    din           ev ek     ed
    vecs[0]  = mk(1, 0, 1, 2, 4'hF, 4'h1, 32'h000000BC, 1, 4'h1, 32'hC017FFBC);
    vecs[1]  = mk(1, 0, 1, 2, 4'h9, 4'h7, 32'h001C1CBC, 1, 4'h7, 32'hFF1C1CBC);
    vecs[2]  = mk(1, 0, 0, 2, 4'hF, 4'h0, 32'h00000000, 1, 4'h0, 32'hB214C017);
    vecs[3]  = mk(1, 1, 1, 2, 4'hF, 4'h1, 32'h4A4A4ABC, 1, 4'h1, 32'h4A4A4ABC);
    vecs[4]  = mk(1, 0, 0, 2, 4'hF, 4'h0, 32'h00000000, 1, 4'h0, 32'h14C017FF);
    vecs[5]  = mk(1, 0, 1, 0, 4'hF, 4'h1, 32'hAAAAAABC, 1, 4'h1, 32'h000000BC);
    vecs[6]  = mk(1, 0, 0, 0, 4'hF, 4'h0, 32'h55555500, 1, 4'h0, 32'h000000FF);
    vecs[7]  = mk(1, 0, 0, 0, 4'hF, 4'h0, 32'h55555500, 1, 4'h0, 32'h00000017);
    vecs[8]  = mk(1, 0, 0, 0, 4'hF, 4'h0, 32'h55555500, 1, 4'h0, 32'h000000C0);
    vecs[9]  = mk(1, 0, 0, 0, 4'hF, 4'h0, 32'h55555500, 1, 4'h0, 32'h00000014);
    vecs[10] = mk(0, 0, 0, 2, 4'hF, 4'hF, 32'h12345678, 0, 4'h0, 32'h00000014);
    vecs[11] = mk(0, 0, 1, 2, 4'hF, 4'hF, 32'h12345678, 0, 4'h0, 32'h00000014);
    vecs[12] = mk(1, 0, 0, 1, 4'hF, 4'h0, 32'h99990000, 1, 4'h0, 32'h0000E7B2);
    vecs[13] = mk(1, 0, 1, 1, 4'hF, 4'h2, 32'h0000FC00, 1, 4'h2, 32'h0000FC02);
    vecs[14] = mk(1, 0, 1, 2, 4'hF, 4'h4, 32'h00BC0000, 1, 4'h4, 32'hFFBC17FF);
    vecs[15] = mk(1, 0, 0, 2, 4'hF, 4'h1, 32'h000000BC, 1, 4'h1, 32'hB214C0BC);
    vecs[16] = mk(1, 0, 1, 3, 4'hF, 4'hA, 32'hBC00BC00, 1, 4'hA, 32'hBCFFBCE7);
    vecs[17] = mk(1, 0, 0, 2, 4'hF, 4'h0, 32'h00000000, 1, 4'h0, 32'h14C017FF);

    // reset state
    step_c("reset0", 1, 1, 0, 1, 2, 4'hF, 4'hF, 32'hDEADBEEF, 0, 4'h0, 32'h0);
    step_c("reset1", 1, 0, 0, 0, 2, 4'hF, 4'h0, 32'h0, 0, 4'h0, 32'h0);

    for (int i = 0; i < 18; i++) begin
      step_c($sformatf("vec%0d", i), 0, vecs[i].v, vecs[i].t, vecs[i].pr, vecs[i].sel,
             vecs[i].adv, vecs[i].kin, vecs[i].din, vecs[i].exp_v, vecs[i].exp_k, vecs[i].exp_d);
    end

    // idle gaps in 8-bit mode: key sequence continues across the gaps
    step_c("gap_com", 0, 1, 0, 1, 0, 4'hF, 4'h1, 32'hA5A5A5BC, 1, 4'h1, 32'h000000BC);
    step_c("gap_d0", 0, 1, 0, 0, 0, 4'hF, 4'h0, 32'hA5A5A500, 1, 4'h0, 32'h000000FF);
    for (int i = 0; i < 3; i++)
      step_c($sformatf("gap_idle0_%0d", i), 0, 0, 0, 0, 0, 4'hF, 4'h0, 32'h0, 0, 4'h0, 32'h000000FF);
    step_c("gap_d1", 0, 1, 0, 0, 0, 4'hF, 4'h0, 32'hA5A5A500, 1, 4'h0, 32'h00000017);
    for (int i = 0; i < 3; i++)
      step_c($sformatf("gap_idle1_%0d", i), 0, 0, 0, 0, 0, 4'hF, 4'h0, 32'h0, 0, 4'h0, 32'h00000017);
    step_c("gap_d2", 0, 1, 0, 0, 0, 4'hF, 4'h0, 32'hA5A5A500, 1, 4'h0, 32'h000000C0);

    // mid-stream reset after five D words
    step_c("mr_com", 0, 1, 0, 1, 2, 4'hF, 4'h1, 32'h000000BC, 1, 4'h1, 32'hC017FFBC);
    for (int i = 0; i < 5; i++)
      step_m($sformatf("mr_d%0d", i), 0, 1, 0, 0, 2, 4'hF, 4'h0, $urandom);
    step_c("mr_reset", 1, 1, 0, 0, 2, 4'hF, 4'h0, 32'h0, 0, 4'h0, 32'h0);
    step_c("mr_after", 0, 1, 0, 0, 2, 4'hF, 4'h0, 32'h0, 1, 4'h0, 32'h14C017FF);

    // randomized words against the keystream model
    since = 0;
    for (int w = 0; w < 1500; w++) begin
      rst = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 4) != 0);
      t   = ($urandom_range(0, 15) == 0);
      pr  = ($urandom_range(0, 7) == 0);
      sel = 2'($urandom_range(0, 3));
      if (since >= 24) begin v = 1'b1; pr = 1'b1; end
      din = '0; kin = '0; adv = '0;
      for (int i = 0; i < 4; i++) begin
        adv[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) == 0) begin
          kin[i] = 1'b1;
          case ($urandom_range(0, 3))
            0: b = K_COM;
            1: b = K_SKP;
            2: b = 8'hFC;
            default: b = 8'($urandom);
          endcase
        end else begin
          b = 8'($urandom);
        end
        din[8*i +: 8] = b;
      end
      step_m($sformatf("rand%0d", w), rst, v, t, pr, sel, adv, kin, din);
      if (rst || (v && (pr || t))) since = 0;
      else if (v) since++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_descrambler.md
Name: rx_descrambler

Overview:
- Gen1/Gen2 (8b/10b) RX descrambler for one lane.
- Sits directly downstream of the RX symbol-classification stage, which produces patternReset, advance[3:0] and LFSRSel for each PIPE word.
- Holds the 16-bit scrambling LFSR (polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF) and descrambles D-symbols byte-serially within each word.
- Emits registered, descrambled PIPE data to the downstream ordered-set/packet parser.

Parameters:
SEED, 16'hFFFF, LFSR value loaded on reset and on COM
POLY, 16'h0039, Galois feedback taps (bits 5,4,3,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dataIn  in  32  received PIPE data; byte 0 is the earliest symbol
dataKIn  in  4  per-byte K-symbol flag
validIn  in  1  word valid
patternReset  in  1  word contains COM, or the LTSSM bypass is active
advance  in  4  per-byte LFSR advance enable (0 = SKP byte)
LFSRSel  in  2  active width: 0 = 8-bit (byte 0), 1 = 16-bit (bytes 0-1), 2 = 32-bit (bytes 0-3), 3 = treated as 2
turnOff  in  1  LTSSM bypass: no descrambling (TS1/TS2 phases)
dataOut  out  32  descrambled data
dataKOut  out  4  delayed dataKIn
validOut  out  1  delayed validIn

Behaviour:
- Reset: the LFSR loads SEED. dataOut = 0, dataKOut = 0, validOut = 0.
- Latency: exactly 1 clk. All outputs are registered.
- validIn = 0: LFSR holds. validOut <= 0. dataOut and dataKOut hold.
- validIn = 1 and turnOff = 1:
  - dataOut <= dataIn unmodified.
  - LFSR <= SEED at the end of the word.
- validIn = 1 and turnOff = 0: bytes i = 0..N-1 are processed in order, where N = 1/2/4 per LFSRSel. S is the running LFSR state.
  - advance[i] = 0 (SKP): byte passes through; S unchanged.
  - dataKIn[i] = 1, byte = 8'hBC (COM), patternReset = 1: byte passes through; S := SEED.
  - Any other K byte: byte passes through; S := step8(S).
  - D byte: out = byte XOR key8(S); S := step8(S).
- Inactive bytes (i >= N): dataOut byte = 0, dataKOut bit = 0. They never touch S.
- patternReset = 1 with no COM byte found in the active bytes: S := SEED after the last active byte.
- A COM byte with patternReset = 0 is treated as an ordinary K byte and does not reset S.
- step8 / key8, applied 8 times, LSB first for bit j = 0..7:
  - key bit j = S[15].
  - S := {S[14:0], 1'b0} ^ (S[15] ? POLY : 0).
- The final S after the last active byte is registered as the new LFSR.
- Multiple COMs in one word: each one re-seeds, so the last COM wins for subsequent bytes.
- Reset asserted mid-stream overrides all other inputs in that cycle.
- LFSRSel may change only between words. The block samples it every valid cycle with no internal state tied to it.

Decomposition:
- Shared package rx_pkg:
  - K_COM = 8'hBC, K_SKP = 8'h1C.
  - SCR_SEED and SCR_POLY.
  - Width-select codes SEL_8 = 0, SEL_16 = 1, SEL_32 = 2.
- One combinational sub-module, scr_byte_step: inputs S[15:0] and byte classification; outputs key[7:0] and S_next[15:0].
- The top level chains four instances of scr_byte_step, muxes with advance/COM/width, and registers the result.

Test Plan:
- Reset, then 32-bit mode: word with byte0 = COM (K), bytes 1-3 = D 8'h00, patternReset = 1, advance = F -> the next cycle gives dataOut = {8'hC0, 8'h17, 8'hFF, 8'hBC}, dataKOut = 4'b0001, validOut = 1.
- SKP insertion: COM, SKP, SKP, D 8'h00 with advance = 4'b1001 -> byte 3 = 8'hFF (SKPs do not advance the LFSR). Follow-on word D 8'h00 x4 -> 8'h17, 8'hC0, 8'h14, 8'hB2.
- turnOff = 1 with TS1 bytes (e.g. COM, 8'h4A, 8'h4A, 8'h4A) -> output equals input. The first D byte after turnOff drops descrambles with key 8'hFF.
- 8-bit mode (LFSRSel = 0): COM followed by 4 words of D 8'h00 -> byte-0 outputs FF, 17, C0, 14. Bytes 1-3 of dataOut = 0 throughout.
- validIn gaps: insert 3 idle cycles between D words -> the key sequence continues unbroken and validOut = 0 during the gaps.
- Reset asserted mid-sequence after 5 D words -> outputs zero the next cycle. The next D byte with no COM descrambles with key 8'hFF.
